pulse_train_generator: RTL and testbench

Transmit-side counterpart to the team's edge and one-cycle-pulse detectors. On a start request it emits a programmable train of pulses on a single registered output. Each pulse has a programmable high width and a programmable low gap. Used to drive detector inputs in benches and to generate strobe sequences for downstream control logic.

---
 rtl/pulse_train_generator.sv | 134 +++++++++++++
 tb/tb_pulse_train_generator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_train_generator.sv
// Programmable pulse-train generator: on start, emits num_pulses pulses of high_len cycles separated by low_len gaps.
// Optional abort input enabled by defining PULSE_TRAIN_ABORT_EN.
module pulse_train_generator #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [CNT_W-1:0] num_pulses,
`ifdef PULSE_TRAIN_ABORT_EN
  input  logic             abort,
`endif
  output logic             out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic [CNT_W-1:0] high_cfg, high_cfg_n;
  logic [CNT_W-1:0] low_cfg, low_cfg_n;
  logic             out_n, busy_n, done_n;
  logic             abort_c;

  // Zero widths are remapped to one so the down-counters never wrap.
  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

`ifdef PULSE_TRAIN_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      high_cfg <= '0;
      low_cfg  <= '0;
      out      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rem      <= rem_n;
      high_cfg <= high_cfg_n;
      low_cfg  <= low_cfg_n;
      out      <= out_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rem_n      = rem;
    high_cfg_n = high_cfg;
    low_cfg_n  = low_cfg;
    out_n      = out;
    busy_n     = busy;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (num_pulses != '0) begin
            high_cfg_n = at_least_one(high_len);
            low_cfg_n  = at_least_one(low_len);
            cnt_n      = at_least_one(high_len);
            rem_n      = num_pulses;
            state_n    = HIGH;
            out_n      = 1'b1;
            busy_n     = 1'b1;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      HIGH: begin
        if (cnt == ONE) begin
          out_n = 1'b0;
          if (rem == ONE) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = LOW;
            cnt_n   = low_cfg;
          end
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      LOW: begin
        if (cnt == ONE) begin
          state_n = HIGH;
          out_n   = 1'b1;
          cnt_n   = high_cfg;
          rem_n   = rem - ONE;
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      default: begin
        state_n = IDLE;
        out_n   = 1'b0;
        busy_n  = 1'b0;
      end
    endcase

    // Abort overrides the phase transition and suppresses done.
    if (abort_c && (state != IDLE)) begin
      state_n = IDLE;
      out_n   = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Self-checking bench for pulse_train_generator; define PULSE_TRAIN_ABORT_EN to also exercise abort.
module tb_pulse_train_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] high_len, low_len, num_pulses;
`ifdef PULSE_TRAIN_ABORT_EN
  logic       abort;
`endif
  logic       out, busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pulse_train_generator #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .high_len   (high_len),
    .low_len    (low_len),
    .num_pulses (num_pulses),
`ifdef PULSE_TRAIN_ABORT_EN
    .abort      (abort),
`endif
    .out        (out),
    .busy       (busy),
    .done       (done)
  );

  // Reference: expected train length from the remapped widths.
  function automatic int train_len(input int h, input int l, input int n);
    int hh, ll;
    hh = (h == 0) ? 1 : h;
    ll = (l == 0) ? 1 : l;
    return (n == 0) ? 0 : n * hh + (n - 1) * ll;
  endfunction

  // Reference: expected out level k cycles after the accept edge.
  function automatic logic model_out(input int h, input int l, input int n, input int k);
    int hh, ll;
    hh = (h == 0) ? 1 : h;
    ll = (l == 0) ? 1 : l;
    if (k >= train_len(h, l, n)) return 1'b0;
    return ((k % (hh + ll)) < hh);
  endfunction

  task automatic drive_start(input int h, input int l, input int n);
    start      = 1'b1;
    high_len   = 8'(h);
    low_len    = 8'(l);
    num_pulses = 8'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on the negedge of the first cycle after accept; ends one cycle past done.
  task automatic check_train(input string name, input int h, input int l, input int n,
                             input bit perturb, input bit chain,
                             input int ch, input int cl, input int cn);
    int len, pulses;
    logic prev;
    len    = train_len(h, l, n);
    pulses = 0;
    prev   = 1'b0;
    for (int k = 0; k <= len; k++) begin
      checks++;
      if (out !== model_out(h, l, n, k)) begin
        errors++;
        $display("FAIL %s out k=%0d: got %b expected %b", name, k, out, model_out(h, l, n, k));
      end
      checks++;
      if (busy !== (k < len)) begin
        errors++;
        $display("FAIL %s busy k=%0d: got %b expected %b", name, k, busy, (k < len));
      end
      checks++;
      if (done !== (k == len)) begin
        errors++;
        $display("FAIL %s done k=%0d: got %b expected %b", name, k, done, (k == len));
      end
      if (out === 1'b1 && prev === 1'b0) pulses++;
      prev = out;
      if (k < len && perturb) begin
        start      = 1'($urandom);
        high_len   = 8'($urandom_range(0, 7));
        low_len    = 8'($urandom_range(0, 7));
        num_pulses = 8'($urandom_range(0, 7));
      end else if (k == len && chain) begin
        start      = 1'b1;
        high_len   = 8'(ch);
        low_len    = 8'(cl);
        num_pulses = 8'(cn);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (pulses != n) begin
      errors++;
      $display("FAIL %s pulse_count: got %0d expected %0d", name, pulses, n);
    end
    if (chain) begin
      start = 1'b0;
    end else begin
      checks++;
      if ({out, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL %s idle_after: got %b expected 000", name, {out, busy, done});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    high_len = '0;
    low_len = '0;
    num_pulses = '0;
`ifdef PULSE_TRAIN_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if ({out, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: got %b expected 000", {out, busy, done});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_idle: got %b expected 000", {out, busy, done});
    end
  endtask

  task automatic test_directed();
    drive_start(1, 2, 3);
    check_train("h1l2n3", 1, 2, 3, 1'b0, 1'b0, 0, 0, 0);
    drive_start(3, 0, 2);
    check_train("h3l0n2", 3, 0, 2, 1'b0, 1'b0, 0, 0, 0);
    drive_start(0, 0, 1);
    check_train("h0l0n1", 0, 0, 1, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_empty();
    drive_start(4, 4, 0);
    check_train("empty", 4, 4, 0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_ignore_midtrain();
    drive_start(1, 2, 3);
    check_train("ignore", 1, 2, 3, 1'b1, 1'b0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    drive_start(2, 1, 2);
    check_train("b2b_first", 2, 1, 2, 1'b0, 1'b1, 1, 3, 2);
    check_train("b2b_second", 1, 3, 2, 1'b0, 1'b1, 0, 0, 0);
    check_train("b2b_empty", 0, 0, 0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_random();
    int h, l, n;
    for (int i = 0; i < 12; i++) begin
      h = int'($urandom_range(0, 5));
      l = int'($urandom_range(0, 5));
      n = int'($urandom_range(0, 5));
      drive_start(h, l, n);
      check_train("random", h, l, n, (i % 2) == 1, 1'b0, 0, 0, 0);
    end
  endtask

  task automatic test_async_reset();
    drive_start(4, 3, 3);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({out, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: got %b expected 000", {out, busy, done});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({out, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL post_reset_quiet k=%0d: got %b expected 000", k, {out, busy, done});
      end
    end
    drive_start(1, 2, 3);
    check_train("after_reset", 1, 2, 3, 1'b0, 1'b0, 0, 0, 0);
  endtask

`ifdef PULSE_TRAIN_ABORT_EN
  task automatic test_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({out, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL abort_idle: got %b expected 000", {out, busy, done});
    end
    drive_start(2, 2, 4);
    // cycles 0-1 high, 2-3 gap, 4-5 high, 6-7 second gap
    for (int k = 0; k < 6; k++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({out, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL abort_gap k=%0d: got %b expected 000", k, {out, busy, done});
      end
      @(negedge clk);
    end
    abort = 1'b1;
    drive_start(2, 2, 4);
    abort = 1'b0;
    check_train("abort_start_same_edge", 2, 2, 4, 1'b0, 1'b0, 0, 0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_empty();
    test_ignore_midtrain();
    test_back_to_back();
    test_random();
    test_async_reset();
`ifdef PULSE_TRAIN_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
